// File: rtl/cmd_issuer.sv
// Serialises one command request into opcode/count/payload bytes and collects the '0'/'1' reply into rsp_bits.
// Accepts in IDLE only (req_ready); each byte waits on tx_ready_i; rsp_valid pulses one cycle after completion.
module cmd_issuer #(
  parameter int MAX_BITS = 64,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [7:0]          req_cmd,
  input  logic [15:0]         req_count,
  input  logic [MAX_BITS-1:0] req_bits,
  output logic                tx_start_o,
  output logic [7:0]          tx_data_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data,
  input  logic                new_rx_data,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_bits,
  output logic [15:0]         rsp_count,
  output logic                rsp_error,
  output logic                busy
);

  localparam int IW = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE, TX_WAIT_RDY, TX_START, TX_WAIT_ACK, NEXT, RX_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {PH_OPC, PH_CNT_HI, PH_CNT_LO, PH_PAY} phase_t;

  state_t              state, state_nxt;
  phase_t              phase;
  logic [7:0]          cmd;
  logic [15:0]         count;
  logic [MAX_BITS-1:0] bits;
  logic [15:0]         idx;
  logic [16:0]         rx_cnt;
  logic [16:0]         rx_len;
  logic [23:0]         timer;

  logic has_cnt, is_pay, is_g, is_o;
  logic pay_bit, rx_is_bit, last_rx, timeout_hit;

  assign is_g    = (cmd == 8'h67);
  assign is_o    = (cmd == 8'h6f);
  assign is_pay  = (cmd == 8'h73) || (cmd == 8'h69);
  assign has_cnt = is_pay || is_g || is_o || (cmd == 8'h65);

  assign pay_bit     = (32'(idx) < MAX_BITS) ? bits[idx[IW-1:0]] : 1'b0;
  assign rx_is_bit   = (rx_data == 8'h30) || (rx_data == 8'h31);
  assign last_rx     = new_rx_data && ((rx_cnt + 17'd1) == rx_len);
  // Timer is 1 on the first idle cycle, so expiry lands TIMEOUT cycles after the last character.
  assign timeout_hit = !new_rx_data && (timer >= 24'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (req_valid) state_nxt = TX_WAIT_RDY;
      TX_WAIT_RDY: if (tx_ready_i) state_nxt = TX_START;
      TX_START:    state_nxt = TX_WAIT_ACK;
      TX_WAIT_ACK: if (!tx_ready_i) state_nxt = NEXT;
      NEXT: begin
        case (phase)
          PH_OPC:    state_nxt = has_cnt ? TX_WAIT_RDY : DONE;
          PH_CNT_HI: state_nxt = TX_WAIT_RDY;
          PH_CNT_LO: begin
            if (is_pay && count != 16'd0)               state_nxt = TX_WAIT_RDY;
            else if (is_g || (is_o && count != 16'd0))  state_nxt = RX_WAIT;
            else                                        state_nxt = DONE;
          end
          PH_PAY:    state_nxt = ((idx + 16'd1) == count) ? DONE : TX_WAIT_RDY;
        endcase
      end
      RX_WAIT:     if (last_rx || timeout_hit) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= PH_OPC;
      cmd       <= 8'd0;
      count     <= 16'd0;
      bits      <= '0;
      idx       <= 16'd0;
      rx_cnt    <= 17'd0;
      rx_len    <= 17'd0;
      timer     <= 24'd0;
      rsp_bits  <= '0;
      rsp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cmd       <= req_cmd;
            count     <= req_count;
            bits      <= req_bits;
            phase     <= PH_OPC;
            idx       <= 16'd0;
            rx_cnt    <= 17'd0;
            rsp_bits  <= '0;
            rsp_error <= 1'b0;
          end
        end
        NEXT: begin
          timer <= 24'd1;
          case (phase)
            PH_OPC:    phase <= PH_CNT_HI;
            PH_CNT_HI: phase <= PH_CNT_LO;
            PH_CNT_LO: begin
              phase  <= PH_PAY;
              idx    <= 16'd0;
              // 17-bit length so "g" with count 0xFFFF expects 65536 characters.
              rx_len <= is_g ? ({1'b0, count} + 17'd1) : {1'b0, count};
            end
            PH_PAY:    idx <= idx + 16'd1;
          endcase
        end
        RX_WAIT: begin
          if (new_rx_data) begin
            rx_cnt <= rx_cnt + 17'd1;
            timer  <= 24'd1;
            if (32'(rx_cnt) < MAX_BITS) rsp_bits[rx_cnt[IW-1:0]] <= (rx_data == 8'h31);
            if (!rx_is_bit) rsp_error <= 1'b1;
          end else begin
            timer <= timer + 24'd1;
            if (timeout_hit) rsp_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_data_o = cmd;
    case (phase)
      PH_OPC:    tx_data_o = cmd;
      PH_CNT_HI: tx_data_o = count[15:8];
      PH_CNT_LO: tx_data_o = count[7:0];
      PH_PAY:    tx_data_o = pay_bit ? 8'h31 : 8'h30;
    endcase
  end

  // Start stays up through TX_WAIT_ACK until the transmitter acknowledges by dropping ready.
  assign tx_start_o = (state == TX_START) || ((state == TX_WAIT_ACK) && tx_ready_i);
  assign req_ready  = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_count  = rx_cnt[15:0];

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: registered transmitter model, character responder and byte/response reference model.
module tb_cmd_issuer;
  localparam int MB = 8;
  localparam int TO = 50;
  typedef logic [7:0] u8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [7:0]    req_cmd = 8'd0;
  logic [15:0]   req_count = 16'd0;
  logic [MB-1:0] req_bits = '0;
  logic          tx_start_o;
  logic [7:0]    tx_data_o;
  logic          tx_ready_i = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          new_rx_data = 1'b0;
  logic          rsp_valid;
  logic [MB-1:0] rsp_bits;
  logic [15:0]   rsp_count;
  logic          rsp_error;
  logic          busy;

  cmd_issuer #(.MAX_BITS(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_count(req_count), .req_bits(req_bits),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .rx_data(rx_data), .new_rx_data(new_rx_data), .rsp_valid(rsp_valid),
    .rsp_bits(rsp_bits), .rsp_count(rsp_count), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc_n = 0;
  u8  got[$];
  u8  exp_q[$];
  u8  rx_q[$];
  u8  src[$];
  bit tx_pend = 0;
  int busy_left = 0;
  int tx_busy_len = 3;
  int last_fall = -100;
  int last_rx = -100;
  bit rx_armed = 0;
  int rx_gap = 0;
  int exp_tx_n = 0;
  int rv_n = 0;
  int rv_cyc = 0;
  int first_start = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One cycle, framed at the falling edge: sample DUT, then move transmitter/responder models.
  task automatic cyc();
    logic s_start, s_rdy;
    u8    s_dat;
    @(negedge clk);
    cyc_n++;
    s_start = tx_start_o;
    s_rdy   = tx_ready_i;
    s_dat   = tx_data_o;
    if (rsp_valid) begin rv_n++; rv_cyc = cyc_n; end
    if (s_start && first_start < 0) first_start = cyc_n;
    new_rx_data = 1'b0;
    if (tx_pend) begin
      tx_ready_i = 1'b0; tx_pend = 0; busy_left = tx_busy_len; last_fall = cyc_n;
    end else if (!s_rdy) begin
      if (busy_left > 0) busy_left--; else tx_ready_i = 1'b1;
    end else if (s_start) begin
      got.push_back(s_dat); tx_pend = 1;
    end
    if (rx_armed && got.size() == exp_tx_n && !tx_pend && cyc_n >= last_fall + 2) begin
      if (rx_gap > 0) rx_gap--;
      else if (rx_q.size() > 0) begin
        rx_data = rx_q.pop_front(); new_rx_data = 1'b1; last_rx = cyc_n;
        rx_gap = $urandom_range(0, 2);
      end
    end else if (busy && $urandom_range(0, 5) == 0) begin
      rx_data = 8'h31; new_rx_data = 1'b1;   // stray strobe outside the receive window
    end
  endtask

  task automatic run(input u8 c, input int cnt, input logic [MB-1:0] b, input int blen);
    int n_rx, acc, k;
    logic [MB-1:0] e_bits;
    logic e_err;
    exp_q.delete();
    exp_q.push_back(c);
    if (c inside {"e", "s", "i", "g", "o"}) begin
      exp_q.push_back(u8'(cnt / 256));
      exp_q.push_back(u8'(cnt % 256));
    end
    if (c inside {"s", "i"})
      for (int i = 0; i < cnt; i++) exp_q.push_back((i < MB && b[i]) ? 8'h31 : 8'h30);
    n_rx = (c == "g") ? cnt + 1 : (c == "o") ? cnt : 0;
    e_bits = '0;
    e_err = (src.size() < n_rx);
    for (int i = 0; i < src.size(); i++) begin
      if (i < MB) e_bits[i] = (src[i] == 8'h31);
      if (src[i] != 8'h30 && src[i] != 8'h31) e_err = 1'b1;
    end

    k = 0;
    while (!(req_ready && tx_ready_i && !tx_pend) && k < 100) begin cyc(); k++; end
    got.delete(); rv_n = 0; first_start = -1;
    rx_q = src; rx_armed = (n_rx > 0); exp_tx_n = exp_q.size();
    rx_gap = $urandom_range(0, 2); tx_busy_len = blen;
    req_valid = 1'b1; req_cmd = c; req_count = 16'(cnt); req_bits = b;
    acc = cyc_n;
    cyc();
    req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("req_ready_busy", req_ready, 0);
    k = 0;
    while (rv_n == 0 && k < 3000) begin cyc(); k++; end
    chk("rsp_valid_seen", rv_n, 1);
    cyc();
    cyc();
    chk("rsp_valid_one_cycle", rv_n, 1);
    chk("req_ready_after", req_ready, 1);
    chk("first_start_T+2", first_start, acc + 2);
    chk("tx_byte_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), got[i], exp_q[i]);
    chk("rsp_bits", rsp_bits, e_bits);
    chk("rsp_count", rsp_count, src.size());
    chk("rsp_error", rsp_error, e_err);
    if (n_rx == 0)                chk("rsp_lat_tx", rv_cyc, last_fall + 2);
    else if (src.size() == n_rx)  chk("rsp_lat_rx", rv_cyc, last_rx + 1);
    else                          chk("rsp_lat_timeout", rv_cyc, last_rx + TO);
    rx_armed = 0;
  endtask

  initial begin
    int cnt, n_rx, nsend, k;
    u8 c;
    u8 cmds[9];
    cmds = '{"r", "e", "f", "p", "s", "g", "i", "o", "z"};

    cyc(); cyc();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_count", rsp_count, 0);
    chk("rst_rsp_error", rsp_error, 0);
    rst = 1'b0;
    cyc();
    chk("req_ready_release", req_ready, 1);

    src.delete(); run("e", 16'h0102, '0, 10);
    src.delete(); run("i", 4, 8'b0000_1010, 3);
    src = '{"1", "0", "1", "1"}; run("g", 3, '0, 2);
    src = '{"1", "x"}; run("o", 2, '0, 2);
    src = '{"1", "0"}; run("o", 5, '0, 1);
    src.delete(); run("s", 10, 8'hff, 1);
    src = '{"1"}; run("g", 0, '0, 1);
    src.delete(); run("o", 0, '0, 1);
    src = '{"1", "1", "0", "1", "0", "0", "1", "1", "1", "0", "1"}; run("g", 10, '0, 1);
    src.delete(); run("z", 7, '0, 2);

    for (int t = 0; t < 20; t++) begin
      c = cmds[$urandom_range(0, 8)];
      cnt = $urandom_range(0, 12);
      n_rx = (c == "g") ? cnt + 1 : (c == "o") ? cnt : 0;
      nsend = n_rx;
      if (n_rx > 1 && $urandom_range(0, 4) == 0) nsend = $urandom_range(1, n_rx - 1);
      src.delete();
      for (int i = 0; i < nsend; i++)
        src.push_back(($urandom_range(0, 7) == 0) ? 8'h78 : ($urandom_range(0, 1) ? 8'h31 : 8'h30));
      run(c, cnt, MB'($urandom), $urandom_range(1, 6));
    end

    // Reset while the second payload byte of an "s" is being offered.
    src.delete(); rx_armed = 0; exp_tx_n = 99; got.delete(); rv_n = 0; tx_busy_len = 2;
    req_valid = 1'b1; req_cmd = "s"; req_count = 16'd6; req_bits = 8'h2d;
    cyc();
    req_valid = 1'b0;
    k = 0;
    while (got.size() < 5 && k < 500) begin cyc(); k++; end
    chk("rst_reached_payload", got.size(), 5);
    rst = 1'b1;
    #1;
    chk("midrst_tx_start", tx_start_o, 0);
    chk("midrst_busy", busy, 0);
    tx_pend = 0; tx_ready_i = 1'b1; busy_left = 0;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("midrst_no_rsp_valid", rv_n, 0);
    src = '{"0", "1", "1"}; run("o", 3, '0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Host-side initiator for the tester's serial command protocol: accepts one command request at a time, serialises it into the byte stream understood by the command parser (opcode, 16-bit count, '0'/'1' payload characters) and collects any '0'/'1' response characters into a bit vector. It sits between an on-chip sequencer or self-test bench and a byte transmitter/receiver pair. This lets the parser and DUT interface be driven in loopback without a PC.

## Interface
- MAX_BITS, 64: width of payload and response vectors.
- TIMEOUT, 1000000: idle clk cycles allowed between response characters; range 1 to 2^24-1.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready
- req_cmd  in  8  opcode: "r","e","f","p","s","g","i","o"
- req_count  in  16  count field
- req_bits  in  MAX_BITS  payload; bit 0 sent first
- tx_start_o  out  1  start request to byte transmitter
- tx_data_o  out  8  byte to transmit
- tx_ready_i  in  1  transmitter idle
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle strobe, rx_data valid
- rsp_valid  out  1  one-cycle completion pulse
- rsp_bits  out  MAX_BITS  received bits; first character in bit 0
- rsp_count  out  16  response characters actually received
- rsp_error  out  1  timeout or non-'0'/'1' character; valid with rsp_valid
- busy  out  1  high whenever state != IDLE

## Operation
- On acceptance, latch cmd, count and bits; clear rsp_bits, rsp_count and the error flag.
- Byte sequence by opcode:
  - "r", "f", "p", and any unknown opcode: opcode only.
  - "e": opcode, count[15:8], count[7:0].
  - "s", "i": as "e", then count payload characters, "1" if bit set else "0". Bits at index >= MAX_BITS are sent as "0".
  - "g": as "e", then receive count+1 characters.
  - "o": as "e", then receive count characters.
- count = 0 with "s"/"i"/"o": no payload or response phase. "g" with count = 0 still expects 1 character.
- Transmit handshake, per byte:
  - TX_WAIT_RDY: wait for tx_ready_i = 1.
  - TX_START: drive tx_data_o and assert tx_start_o; hold both until tx_ready_i = 0.
  - TX_WAIT_ACK: on tx_ready_i = 0, deassert tx_start_o, then advance to the next byte.
- Receive phase (RX_WAIT):
  - On each new_rx_data, "1" writes 1 and "0" writes 0 at index rsp_count. Any other byte writes 0 and sets the error flag.
  - Index >= MAX_BITS: the bit is discarded, but rsp_count still increments.
  - Timeout counter clears on each new_rx_data. When it reaches TIMEOUT, set the error flag and go to DONE.
  - new_rx_data outside RX_WAIT is ignored.
- States: IDLE, TX_WAIT_RDY, TX_START, TX_WAIT_ACK, NEXT (select next byte or phase), RX_WAIT, DONE.
  - IDLE goes to TX_WAIT_RDY on acceptance.
  - DONE pulses rsp_valid and returns to IDLE.
- Byte counter: 16-bit plus phase index. "g" expected length is computed in 17 bits, so count = 0xFFFF expects 65536 characters without wrap.

## Timing
- Reset values: req_ready 0 while rst is high, 1 on the first cycle after release (IDLE). All other outputs are 0.
- Acceptance cycle T: busy = 1 from T+1. tx_start_o rises at T+2 at the earliest, if tx_ready_i is already 1.
- tx_data_o is stable from the tx_start_o rising cycle until the cycle after tx_ready_i falls.
- rsp_valid is high for exactly 1 cycle. req_ready returns the following cycle, so back-to-back requests are spaced by at least 2 cycles.
- For no-response commands, rsp_valid comes 2 cycles after the last tx_ready_i fall.
- For response commands, rsp_valid comes 1 cycle after the final new_rx_data.
- rsp_bits, rsp_count and rsp_error hold their values until the next acceptance.
- If new_rx_data and timeout expiry fall on the same cycle, the data is accepted and the timeout counter clears.
- rst mid-operation: immediate return to IDLE. tx_start_o drops asynchronously and no rsp_valid is issued.

## Test plan
- Send "e" with count 0x0102 against a transmitter model with 10-cycle busy → bytes 0x65, 0x01, 0x02 in order, each start held until ready falls; rsp_valid with rsp_error = 0 and rsp_count = 0.
- Send "i" with count 4 and bits 4'b1010 → bytes "i", 0x00, 0x04, "0", "1", "0", "1".
- Send "g" with count 3; responder returns "1","0","1","1" → rsp_bits[3:0] = 4'b1101, rsp_count = 4, rsp_error = 0.
- Send "o" with count 2; responder returns "1","x" → rsp_bits[1:0] = 2'b01, rsp_error = 1.
- Send "o" with count 5 and TIMEOUT = 50; responder returns 2 characters then stays silent → rsp_valid 50 cycles after the 2nd character, rsp_count = 2, rsp_error = 1.
- Assert rst during the 2nd payload byte of "s" → tx_start_o = 0 and busy = 0 immediately; no rsp_valid; the next request after release behaves normally.
